mc_ctrl_fsm: RTL
================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multi-cycle MIPS control unit: FSM driving datapath selects per phase (IF/ID/EX/MEM/WB).
//  Successor to the single-cycle combinational decoder. Adds lw/sw, bne, jal, and
//  req/ack memory handshakes with timeout-to-exception. Illegal opcodes raise exception.
//  Sits between instruction register (opcode/funct) and multi-cycle datapath (PC, IR, RF, ALU, DM).
// PARAMETERS
//  ALUOP_W      5   width of alu_op; values are the codebase ALUOp_* encodings
//  NPCOP_W      3   width of npc_op
//  ACK_TIMEOUT  16  max wait cycles for imem_ack/dmem_ack before exception; 0 = never time out
//  CNT_W        5   wait-counter width; must satisfy 2**CNT_W > ACK_TIMEOUT
// PORTS
//  clk       in   1        rising-edge clock
//  rst_n     in   1        asynchronous active-low reset
//  opcode    in   6        IR[31:26]; valid from ID onward
//  funct     in   6        IR[5:0]
//  zero      in   1        ALU zero flag, sampled in EX
//  imem_ack  in   1        instruction memory ack (1-cycle pulse)
//  dmem_ack  in   1        data memory ack (1-cycle pulse)
//  imem_req  out  1        instruction fetch request
//  ir_wr     out  1        IR load strobe
//  dmem_req  out  1        data memory request
//  dmem_we   out  1        data memory write (valid with dmem_req)
//  pc_wr     out  1        PC <= NPC strobe
//  npc_op    out  NPCOP_W  0 PLUS4, 1 BRANCH, 2 JUMP, 4 EXCEPT
//  rf_wr     out  1        register file write
//  alu_op    out  ALUOP_W  ALU operation
//  a_sel     out  1        1 = shamt as ALU A (sll/srl/sra)
//  b_sel     out  1        1 = extended immediate as ALU B
//  ext_op    out  2        0 zero-extend, 1 sign-extend
//  gpr_sel   out  2        dest reg: 0 rd, 1 rt, 2 $31
//  wd_sel    out  2        RF write data: 0 ALU, 1 DM, 2 PC+4
//  exc       out  1        exception pulse (one cycle in EXC)
//  state     out  3        IF=0 ID=1 EX=2 MEM=3 WB=4 EXC=5
// BEHAVIOUR
//  Reset: state=IF, wait counter=0, latched class=none.
//  - While rst_n low, all outputs are 0.
//  - imem_req rises in the first cycle after deassertion.
//  Reset mid-operation: immediate return to IF. No pc_wr/rf_wr/dmem_req glitch; pending ack is ignored.
//  Outputs: Moore decode of state + instruction class latched in ID. zero is used in EX only.
//  IF:
//  - imem_req=1.
//  - On imem_ack: ir_wr=1, -> ID.
//  - No ack: counter++. Counter==ACK_TIMEOUT -> EXC.
//  ID:
//  - Latch class from opcode/funct: R, I (addi/addiu/andi/ori/xori/lui/slti/sltiu), LW, SW, BEQ, BNE, J, JAL.
//  - Illegal opcode or unknown R funct -> EXC. Otherwise -> EX.
//  EX:
//  - R: alu_op per funct, a_sel=shift-by-shamt, b_sel=0 -> WB.
//  - I: b_sel=1; ext_op=1 for addi/addiu/slti/sltiu, else 0 -> WB.
//  - LW/SW: ALUOp_ADD, b_sel=1, ext_op=1 -> MEM.
//  - BEQ/BNE: ALUOp_SUB; pc_wr=1; npc_op=BRANCH if (BEQ&zero)|(BNE&!zero), else PLUS4 -> IF.
//  - J: pc_wr=1, npc_op=JUMP -> IF.
//  - JAL -> WB.
//  MEM:
//  - dmem_req=1; dmem_we=1 for SW. Held until dmem_ack (same timeout rule as IF).
//  - On ack: SW does pc_wr=1, npc_op=PLUS4 -> IF. LW -> WB.
//  WB:
//  - rf_wr=1 and pc_wr=1 (one cycle) -> IF.
//  - R: gpr_sel=0, wd_sel=0. I: gpr_sel=1, wd_sel=0. LW: gpr_sel=1, wd_sel=1.
//  - JAL: gpr_sel=2, wd_sel=2, npc_op=JUMP. All others: npc_op=PLUS4.
//  EXC: exc=1, pc_wr=1, npc_op=EXCEPT, rf_wr=0 -> IF. One cycle only.
//  Wait counter: cleared on every state change; saturates; unused when ACK_TIMEOUT=0.
//  Ack outside its wait state is ignored. Ack and timeout in same cycle: ack wins.
//  Unused select outputs are 0 in every state.
//  Cycles per instruction with zero-wait memory: R/I/JAL/SW 4, LW 5, BEQ/BNE/J 3, illegal 3.
// TESTING
//  1. Reset release, imem_ack tied to imem_req, addu (op 0, funct 0x21): IF,ID,EX,WB.
//     rf_wr=1 and pc_wr=1 in cycle 4; npc_op=0, gpr_sel=0.
//  2. lw, dmem_ack 2 cycles after dmem_req: dmem_req held 3 cycles, dmem_we=0.
//     WB has wd_sel=1, gpr_sel=1; 7 cycles total.
//  3. beq with zero=1 -> pc_wr, npc_op=1 in EX. bne with zero=1 -> npc_op=0. 3 cycles each.
//  4. jal: WB has gpr_sel=2, wd_sel=2, npc_op=2, rf_wr=1.
//     Opcode 0x3F: exc=1, npc_op=4 in cycle 3, no rf_wr.
//  5. ACK_TIMEOUT=16, imem_ack never asserted: EXC on wait cycle 16, exc pulse, back to IF.
//     Ack on cycle 16: ID (ack wins).
//  6. rst_n low during MEM of sw: outputs 0 immediately, dmem_req drops.
//     After release, state=IF; late dmem_ack is ignored.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EX/MEM/WB and drives datapath selects
// as a Moore decode of the current phase plus the instruction class latched in ID.
module mc_ctrl_fsm #(
  parameter int ALUOP_W     = 5,
  parameter int NPCOP_W     = 3,
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               imem_ack,
  input  logic               dmem_ack,
  output logic               imem_req,
  output logic               ir_wr,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic               pc_wr,
  output logic [NPCOP_W-1:0] npc_op,
  output logic               rf_wr,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               a_sel,
  output logic               b_sel,
  output logic [1:0]         ext_op,
  output logic [1:0]         gpr_sel,
  output logic [1:0]         wd_sel,
  output logic               exc,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_EXC = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_I, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL
  } class_e;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_NOR  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(10);
  localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(11);
  localparam logic [ALUOP_W-1:0] ALU_ADDU = ALUOP_W'(12);
  localparam logic [ALUOP_W-1:0] ALU_SUBU = ALUOP_W'(13);

  localparam logic [NPCOP_W-1:0] NPC_PLUS4  = NPCOP_W'(0);
  localparam logic [NPCOP_W-1:0] NPC_BRANCH = NPCOP_W'(1);
  localparam logic [NPCOP_W-1:0] NPC_JUMP   = NPCOP_W'(2);
  localparam logic [NPCOP_W-1:0] NPC_EXCEPT = NPCOP_W'(4);

  localparam int TO_LAST = (ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1;

  state_e             state_q, state_d;
  class_e             cls_q, cls_d, dec_cls;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ALUOP_W-1:0] aluop_q, aluop_d, dec_alu;
  logic               shamt_q, shamt_d, dec_shamt;
  logic               sext_q, sext_d, dec_sext;
  logic               timeout_hit;

  // Timeout fires on the last allowed wait cycle; an ack in that cycle still wins.
  assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST));
  assign state       = state_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    dec_cls   = C_NONE;
    dec_alu   = ALU_ADD;
    dec_shamt = 1'b0;
    dec_sext  = 1'b0;
    case (opcode)
      6'h00: begin
        dec_cls = C_R;
        case (funct)
          6'h00: begin dec_alu = ALU_SLL; dec_shamt = 1'b1; end
          6'h02: begin dec_alu = ALU_SRL; dec_shamt = 1'b1; end
          6'h03: begin dec_alu = ALU_SRA; dec_shamt = 1'b1; end
          6'h04: dec_alu = ALU_SLL;
          6'h06: dec_alu = ALU_SRL;
          6'h07: dec_alu = ALU_SRA;
          6'h20: dec_alu = ALU_ADD;
          6'h21: dec_alu = ALU_ADDU;
          6'h22: dec_alu = ALU_SUB;
          6'h23: dec_alu = ALU_SUBU;
          6'h24: dec_alu = ALU_AND;
          6'h25: dec_alu = ALU_OR;
          6'h26: dec_alu = ALU_XOR;
          6'h27: dec_alu = ALU_NOR;
          6'h2A: dec_alu = ALU_SLT;
          6'h2B: dec_alu = ALU_SLTU;
          default: dec_cls = C_NONE;
        endcase
      end
      6'h08: begin dec_cls = C_I; dec_alu = ALU_ADD;  dec_sext = 1'b1; end
      6'h09: begin dec_cls = C_I; dec_alu = ALU_ADDU; dec_sext = 1'b1; end
      6'h0A: begin dec_cls = C_I; dec_alu = ALU_SLT;  dec_sext = 1'b1; end
      6'h0B: begin dec_cls = C_I; dec_alu = ALU_SLTU; dec_sext = 1'b1; end
      6'h0C: begin dec_cls = C_I; dec_alu = ALU_AND; end
      6'h0D: begin dec_cls = C_I; dec_alu = ALU_OR;  end
      6'h0E: begin dec_cls = C_I; dec_alu = ALU_XOR; end
      6'h0F: begin dec_cls = C_I; dec_alu = ALU_LUI; end
      6'h23: dec_cls = C_LW;
      6'h2B: dec_cls = C_SW;
      6'h04: dec_cls = C_BEQ;
      6'h05: dec_cls = C_BNE;
      6'h02: dec_cls = C_J;
      6'h03: dec_cls = C_JAL;
      default: dec_cls = C_NONE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cls_d   = cls_q;
    aluop_d = aluop_q;
    shamt_d = shamt_q;
    sext_d  = sext_q;
    case (state_q)
      S_IF: begin
        if (imem_ack)         state_d = S_ID;
        else if (timeout_hit) state_d = S_EXC;
        else if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      end
      S_ID: begin
        cls_d   = dec_cls;
        aluop_d = dec_alu;
        shamt_d = dec_shamt;
        sext_d  = dec_sext;
        state_d = (dec_cls == C_NONE) ? S_EXC : S_EX;
      end
      S_EX: begin
        case (cls_q)
          C_R, C_I, C_JAL: state_d = S_WB;
          C_LW, C_SW:      state_d = S_MEM;
          default:         state_d = S_IF;
        endcase
      end
      S_MEM: begin
        if (dmem_ack)         state_d = (cls_q == C_SW) ? S_IF : S_WB;
        else if (timeout_hit) state_d = S_EXC;
        else if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = S_IF;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IF;
      cnt_q   <= '0;
      cls_q   <= C_NONE;
      aluop_q <= ALU_ADD;
      shamt_q <= 1'b0;
      sext_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cls_q   <= cls_d;
      aluop_q <= aluop_d;
      shamt_q <= shamt_d;
      sext_q  <= sext_d;
    end
  end

  // Outputs are forced low while reset is held so no strobe escapes during reset.
  always_comb begin
    imem_req = 1'b0;
    ir_wr    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_wr    = 1'b0;
    npc_op   = NPC_PLUS4;
    rf_wr    = 1'b0;
    alu_op   = ALU_ADD;
    a_sel    = 1'b0;
    b_sel    = 1'b0;
    ext_op   = 2'd0;
    gpr_sel  = 2'd0;
    wd_sel   = 2'd0;
    exc      = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_IF: begin
          imem_req = 1'b1;
          ir_wr    = imem_ack;
        end
        S_EX: begin
          case (cls_q)
            C_R: begin alu_op = aluop_q; a_sel = shamt_q; end
            C_I: begin alu_op = aluop_q; b_sel = 1'b1; ext_op = {1'b0, sext_q}; end
            C_LW, C_SW: begin alu_op = ALU_ADD; b_sel = 1'b1; ext_op = 2'd1; end
            C_BEQ, C_BNE: begin
              alu_op = ALU_SUB;
              pc_wr  = 1'b1;
              if ((cls_q == C_BEQ && zero) || (cls_q == C_BNE && !zero)) npc_op = NPC_BRANCH;
            end
            C_J: begin pc_wr = 1'b1; npc_op = NPC_JUMP; end
            default: ;
          endcase
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls_q == C_SW);
          pc_wr    = dmem_ack && (cls_q == C_SW);
        end
        S_WB: begin
          rf_wr = 1'b1;
          pc_wr = 1'b1;
          case (cls_q)
            C_I:   gpr_sel = 2'd1;
            C_LW:  begin gpr_sel = 2'd1; wd_sel = 2'd1; end
            C_JAL: begin gpr_sel = 2'd2; wd_sel = 2'd2; npc_op = NPC_JUMP; end
            default: ;
          endcase
        end
        S_EXC: begin
          exc    = 1'b1;
          pc_wr  = 1'b1;
          npc_op = NPC_EXCEPT;
        end
        default: ;
      endcase
    end
  end

endmodule
